// File: rtl/tetris_board_if.sv
// Bus between a game controller and the tetris_board playfield store:
// display read port, single-cell write handshake, lock handshake and pass status.
interface tetris_board_if;
  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; ready never depends on valid, and a dropped valid is not queued.
  logic [4:0] rd_x;
  logic [4:0] rd_y;
  logic [3:0] rd_kind;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_x;
  logic [4:0] wr_y;
  logic [3:0] wr_kind;
  logic       lock_valid;
  logic       lock_ready;
  logic       busy;
  logic       clear_done;
  logic [2:0] lines_cleared;

  modport master (
    output rd_x, rd_y, wr_valid, wr_x, wr_y, wr_kind, lock_valid,
    input  rd_kind, wr_ready, lock_ready, busy, clear_done, lines_cleared
  );

  modport slave (
    input  rd_x, rd_y, wr_valid, wr_x, wr_y, wr_kind, lock_valid,
    output rd_kind, wr_ready, lock_ready, busy, clear_done, lines_cleared
  );
endinterface

// File: rtl/tetris_board.sv
// Tetris playfield store with a bottom-up line-clear engine (IDLE/SCAN/SHIFT/DONE).
// Optional TETRIS_BOARD_CLEAR_ALL_EN adds a one-cycle clear_all input usable in IDLE.
module tetris_board #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
) (
  input  logic       clk,
  input  logic       reset_n,
`ifdef TETRIS_BOARD_CLEAR_ALL_EN
  input  logic       clear_all,
`endif
  tetris_board_if.slave bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LAST_ROW = 5'(BOARD_H - 1);

  logic [BOARD_H-1:0][BOARD_W-1:0][3:0] cells_q, cells_d;
  state_t     state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [4:0] shp_q, shp_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] lines_q, lines_d;
  logic [3:0] rd_kind_q, rd_kind_d;
  logic       rdy_q, rdy_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       wipe;
  logic       wr_fire;
  logic       lock_fire;
  logic       row_full;

`ifdef TETRIS_BOARD_CLEAR_ALL_EN
  assign wipe = clear_all;
`else
  assign wipe = 1'b0;
`endif

  // A wipe in IDLE swallows any write or lock offered in the same cycle.
  assign wr_fire   = bus.wr_valid   & (state_q == IDLE) & ~wipe;
  assign lock_fire = bus.lock_valid & (state_q == IDLE) & ~wipe;

  always_comb begin
    cells_d   = cells_q;
    state_d   = state_q;
    row_d     = row_q;
    shp_d     = shp_q;
    cnt_d     = cnt_q;
    lines_d   = lines_q;
    rd_kind_d = '0;
    row_full  = 1'b0;

    // Out-of-range coordinates match no cell, so reads return 0 and writes drop.
    for (int r = 0; r < BOARD_H; r++) begin
      for (int c = 0; c < BOARD_W; c++) begin
        if (5'(r) == bus.rd_y && 5'(c) == bus.rd_x) rd_kind_d = cells_q[r][c];
      end
    end

    for (int r = 0; r < BOARD_H; r++) begin
      if (5'(r) == row_q) begin
        row_full = 1'b1;
        for (int c = 0; c < BOARD_W; c++) begin
          if (cells_q[r][c] == 4'd0) row_full = 1'b0;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (wipe) begin
          cells_d = '0;
        end
        if (wr_fire) begin
          for (int r = 0; r < BOARD_H; r++) begin
            for (int c = 0; c < BOARD_W; c++) begin
              if (5'(r) == bus.wr_y && 5'(c) == bus.wr_x) cells_d[r][c] = bus.wr_kind;
            end
          end
        end
        if (lock_fire) begin
          state_d = SCAN;
          row_d   = LAST_ROW;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (row_full) begin
          cnt_d   = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
          shp_d   = row_q;
          state_d = SHIFT;
        end else if (row_q == 5'd0) begin
          state_d = DONE;
        end else begin
          row_d = row_q - 5'd1;
        end
      end
      SHIFT: begin
        for (int r = 1; r < BOARD_H; r++) begin
          if (5'(r) == shp_q) cells_d[r] = cells_q[r-1];
        end
        // Row pointer is left alone so SCAN re-checks the row that just moved down.
        if (shp_q == 5'd0) begin
          cells_d[0] = '0;
          state_d    = SCAN;
        end else begin
          shp_d = shp_q - 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    if (done_d) lines_d = cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cells_q   <= '0;
      state_q   <= IDLE;
      row_q     <= '0;
      shp_q     <= '0;
      cnt_q     <= '0;
      lines_q   <= '0;
      rd_kind_q <= '0;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cells_q   <= cells_d;
      state_q   <= state_d;
      row_q     <= row_d;
      shp_q     <= shp_d;
      cnt_q     <= cnt_d;
      lines_q   <= lines_d;
      rd_kind_q <= rd_kind_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.rd_kind       = rd_kind_q;
  assign bus.wr_ready      = rdy_q;
  assign bus.lock_ready    = rdy_q;
  assign bus.busy          = busy_q;
  assign bus.clear_done    = done_q;
  assign bus.lines_cleared = lines_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_tetris_board.sv
// Directed bench for tetris_board: reads, writes, line-clear passes, busy
// lockout, count saturation and mid-pass reset, checked against a board model.
module tb_tetris_board;
  localparam int W = 10;
  localparam int H = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  tetris_board_if bus ();

`ifdef TETRIS_BOARD_CLEAR_ALL_EN
  logic clear_all = 1'b0;
  tetris_board #(.BOARD_W(W), .BOARD_H(H)) dut (
    .clk(clk), .reset_n(reset_n), .clear_all(clear_all), .bus(bus), .state_dbg(state_dbg));
`else
  tetris_board #(.BOARD_W(W), .BOARD_H(H)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .state_dbg(state_dbg));
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int done_pulses = 0;
  logic [3:0] exp_q[$];
  logic [3:0] model [H][W];

  always @(negedge clk) if (bus.clear_done === 1'b1) done_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Final board after a pass: full rows vanish, the rest compact towards the bottom.
  function automatic int model_clear();
    logic [3:0] nb [H][W];
    int dst = H - 1;
    int n = 0;
    bit full;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) nb[y][x] = 4'd0;
    for (int s = H - 1; s >= 0; s--) begin
      full = 1'b1;
      for (int x = 0; x < W; x++) if (model[s][x] == 4'd0) full = 1'b0;
      if (full) n++;
      else begin
        for (int x = 0; x < W; x++) nb[dst][x] = model[s][x];
        dst--;
      end
    end
    model = nb;
    return (n > 7) ? 7 : n;
  endfunction

  function automatic logic [3:0] model_at(input int x, input int y);
    if (x < W && y < H) return model[y][x];
    return 4'd0;
  endfunction

  task automatic read_check(input int x, input int y, input string tag);
    bus.rd_x = 5'(x);
    bus.rd_y = 5'(y);
    exp_q.push_back(model_at(x, y));
    @(posedge clk); #1;
    check($sformatf("%s(%0d,%0d)", tag, x, y), 32'(bus.rd_kind), 32'(exp_q.pop_front()));
  endtask

  task automatic check_board(input string tag);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) read_check(x, y, tag);
  endtask

  task automatic write_cell(input int x, input int y, input int k);
    bus.wr_valid = 1'b1;
    bus.wr_x     = 5'(x);
    bus.wr_y     = 5'(y);
    bus.wr_kind  = 4'(k);
    check("wr_ready_idle", 32'(bus.wr_ready), 32'(1));
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    if (x < W && y < H) model[y][x] = 4'(k);
  endtask

  task automatic fill_row(input int y, input int base);
    for (int x = 0; x < W; x++) write_cell(x, y, 1 + (x + base) % 7);
  endtask

  task automatic start_lock();
    exp_q.push_back(4'(model_clear()));
    bus.lock_valid = 1'b1;
    check("lock_ready_idle", 32'(bus.lock_ready), 32'(1));
    @(posedge clk); #1;
    bus.lock_valid = 1'b0;
    check("busy_after_lock", 32'(bus.busy), 32'(1));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int cyc = 0;
    logic [3:0] exp_lines;
    exp_lines = exp_q.pop_front();
    while (bus.clear_done !== 1'b1 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_clear_done"}, 32'(bus.clear_done), 32'(1));
    check({tag, "_lines"}, 32'(bus.lines_cleared), 32'(exp_lines));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'(1));
    @(posedge clk); #1;
    check({tag, "_busy_after"}, 32'(bus.busy), 32'(0));
    check({tag, "_done_pulse_end"}, 32'(bus.clear_done), 32'(0));
    check({tag, "_lines_held"}, 32'(bus.lines_cleared), 32'(exp_lines));
  endtask

  initial begin
    int pre;
    bus.rd_x = '0; bus.rd_y = '0;
    bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_kind = '0;
    bus.lock_valid = 1'b0;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) model[y][x] = 4'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_dbg), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_clear_done", 32'(bus.clear_done), 32'(0));
    check("rst_lines", 32'(bus.lines_cleared), 32'(0));
    check("rst_rd_kind", 32'(bus.rd_kind), 32'(0));
    check("rst_wr_ready", 32'(bus.wr_ready), 32'(1));
    reset_n = 1'b1;

    read_check(0, 0, "rd_reset");
    read_check(9, 19, "rd_reset");
    read_check(10, 5, "rd_oob");
    read_check(31, 31, "rd_oob");

    // Single write, out-of-range writes, erase
    write_cell(4, 7, 3);
    read_check(4, 7, "rd_write");
    write_cell(12, 3, 6);
    write_cell(3, 25, 6);
    check_board("board_oob_write");
    write_cell(4, 7, 0);
    read_check(4, 7, "rd_erase");

    // One full row with a marker above it and a cell in row 0
    fill_row(19, 0);
    write_cell(2, 18, 5);
    write_cell(7, 0, 2);
    start_lock();
    wait_done(200, "single");
    read_check(2, 19, "rd_moved");
    check_board("board_single");

    // Tetris on an otherwise empty board
    write_cell(2, 19, 0);
    write_cell(7, 1, 0);
    for (int y = 16; y < 20; y++) fill_row(y, y);
    start_lock();
    wait_done(400, "tetris");
    check_board("board_tetris");

    // Write and lock offered while busy are ignored
    fill_row(19, 3);
    write_cell(0, 18, 6);
    pre = done_pulses;
    start_lock();
    bus.wr_valid = 1'b1; bus.wr_x = 5'd0; bus.wr_y = 5'd0; bus.wr_kind = 4'd7;
    bus.lock_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("wr_ready_busy", 32'(bus.wr_ready), 32'(0));
      check("lock_ready_busy", 32'(bus.lock_ready), 32'(0));
      @(posedge clk); #1;
    end
    bus.wr_valid = 1'b0;
    bus.lock_valid = 1'b0;
    wait_done(200, "busy");
    repeat (5) @(posedge clk);
    #1;
    check("no_second_pass_busy", 32'(bus.busy), 32'(0));
    check("no_second_pass_pulses", 32'(done_pulses - pre), 32'(1));
    check_board("board_busy");

    // Nine full rows: count saturates at 7
    write_cell(0, 19, 0);
    for (int y = 11; y < 20; y++) fill_row(y, y + 1);
    start_lock();
    wait_done(800, "saturate");
    check_board("board_saturate");

    // Write completes row 19 in the same cycle as the lock; row 17 also full
    fill_row(19, 2);
    write_cell(5, 19, 0);
    fill_row(17, 4);
    write_cell(3, 16, 1);
    bus.wr_valid = 1'b1; bus.wr_x = 5'd5; bus.wr_y = 5'd19; bus.wr_kind = 4'd4;
    bus.lock_valid = 1'b1;
    model[19][5] = 4'd4;
    exp_q.push_back(4'(model_clear()));
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    bus.lock_valid = 1'b0;
    check("busy_write_lock", 32'(bus.busy), 32'(1));
    wait_done(400, "write_lock");
    check_board("board_write_lock");

    // Reset five cycles into a pass
    fill_row(19, 5);
    write_cell(1, 10, 2);
    bus.lock_valid = 1'b1;
    @(posedge clk); #1;
    bus.lock_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midpass_busy", 32'(bus.busy), 32'(1));
    pre = done_pulses;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midrst_state", 32'(state_dbg), 32'(0));
    check("midrst_busy", 32'(bus.busy), 32'(0));
    check("midrst_clear_done", 32'(bus.clear_done), 32'(0));
    check("midrst_lines", 32'(bus.lines_cleared), 32'(0));
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) model[y][x] = 4'd0;
    check_board("board_midrst");
    repeat (50) @(posedge clk);
    #1;
    check("midrst_no_pulse", 32'(done_pulses - pre), 32'(0));
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
